// File: rtl/mips_pkg.sv
// Constants and select encodings shared by the MIPS datapath blocks.
package mips_pkg;

    localparam int WORD_W   = 32;
    localparam int PIPE_MAX = 4;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/mux_pipe_stage.sv
// One pipeline register holding {data, valid, err, sel tag}; flush beats stall.
module mux_pipe_stage #(
    parameter int               WIDTH     = 32,
    parameter int               SEL_W     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             vld_i,
    input  logic             err_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o,
    output logic             err_o,
    output logic [SEL_W-1:0] sel_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q,  vld_d;
    logic             err_q,  err_d;
    logic [SEL_W-1:0] sel_q,  sel_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        err_d  = err_q;
        sel_d  = sel_q;
        if (flush_i) begin
            data_d = RESET_VAL;
            vld_d  = 1'b0;
            err_d  = 1'b0;
            sel_d  = '0;
        end else if (!stall_i) begin
            data_d = data_i;
            vld_d  = vld_i;
            err_d  = err_i;
            sel_d  = sel_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            sel_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            sel_q  <= sel_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign err_o  = err_q;
    assign sel_o  = sel_q;

endmodule

// File: rtl/pipelined_mux_nto1.sv
// N-to-1 word select followed by PIPE register stages carrying valid, error and select tag.
module pipelined_mux_nto1
    import mips_pkg::*;
#(
    parameter int               WIDTH     = WORD_W,
    parameter int               NUM_IN    = 4,
    parameter int               PIPE      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err
);

    generate
        if (PIPE < 1 || PIPE > PIPE_MAX || NUM_IN < 2 || NUM_IN > 16) begin : g_bad_cfg
            $error("pipelined_mux_nto1: PIPE must be 1..4 and NUM_IN 2..16");
        end
    endgenerate

    logic [WIDTH-1:0] data_p0;
    logic             err_p0;

    // Out-of-range selects never index in_bus; they fall through to RESET_VAL.
    always_comb begin
        data_p0 = RESET_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                data_p0 = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign err_p0 = (int'(sel) >= NUM_IN);

    // Index 0 is the combinational stage input, index PIPE the last register.
    logic [WIDTH-1:0] st_data [PIPE+1];
    logic             st_vld  [PIPE+1];
    logic             st_err  [PIPE+1];
    logic [SEL_W-1:0] st_sel  [PIPE+1];

    assign st_data[0] = data_p0;
    assign st_vld[0]  = in_valid;
    assign st_err[0]  = err_p0;
    assign st_sel[0]  = sel;

    for (genvar i = 0; i < PIPE; i++) begin : g_stage
        mux_pipe_stage #(
            .WIDTH     (WIDTH),
            .SEL_W     (SEL_W),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk_i   (Clk),
            .rst_i   (Rst),
            .stall_i (stall),
            .flush_i (flush),
            .data_i  (st_data[i]),
            .vld_i   (st_vld[i]),
            .err_i   (st_err[i]),
            .sel_i   (st_sel[i]),
            .data_o  (st_data[i+1]),
            .vld_o   (st_vld[i+1]),
            .err_o   (st_err[i+1]),
            .sel_o   (st_sel[i+1])
        );
    end

    assign out       = st_data[PIPE];
    assign out_valid = st_vld[PIPE];
    assign sel_err   = st_err[PIPE];
    assign out_sel   = st_sel[PIPE];

endmodule

// File: tb/tb_pipelined_mux_nto1.sv
// Bench for pipelined_mux_nto1: four configurations share one stimulus stream.
module tb_pipelined_mux_nto1;

    typedef struct packed {
        logic [31:0] data;
        logic        vld;
        logic        err;
        logic [1:0]  tag;
    } obs_t;

    localparam int ND = 4;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [127:0] in_bus;
    logic [1:0]   sel;
    logic         in_valid, stall, flush;

    logic [31:0] o_data [ND];
    logic        o_vld  [ND];
    logic        o_err  [ND];
    logic [1:0]  o_sel  [ND];
    obs_t        act    [ND];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pipelined_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .PIPE(1), .RESET_VAL(32'h0)) u_dut_p1 (
        .Clk(Clk), .Rst(Rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(o_data[0]), .out_valid(o_vld[0]),
        .out_sel(o_sel[0]), .sel_err(o_err[0]));

    pipelined_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .PIPE(2), .RESET_VAL(32'h0)) u_dut_p2 (
        .Clk(Clk), .Rst(Rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(o_data[1]), .out_valid(o_vld[1]),
        .out_sel(o_sel[1]), .sel_err(o_err[1]));

    pipelined_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .PIPE(3), .RESET_VAL(32'h0)) u_dut_p3 (
        .Clk(Clk), .Rst(Rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(o_data[2]), .out_valid(o_vld[2]),
        .out_sel(o_sel[2]), .sel_err(o_err[2]));

    pipelined_mux_nto1 #(.WIDTH(32), .NUM_IN(3), .PIPE(2), .RESET_VAL(32'hDEADBEEF)) u_dut_n3 (
        .Clk(Clk), .Rst(Rst), .in_bus(in_bus[95:0]), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(o_data[3]), .out_valid(o_vld[3]),
        .out_sel(o_sel[3]), .sel_err(o_err[3]));

    for (genvar g = 0; g < ND; g++) begin : g_act
        assign act[g] = {o_data[g], o_vld[g], o_err[g], o_sel[g]};
    end

    // Reference model: each configuration keeps the history of words accepted on
    // advancing edges; the output is the word accepted PIPE advances ago.
    obs_t ring [ND][16];
    int   cnt  [ND];

    function automatic int pipe_of(int d);
        case (d)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int num_of(int d);
        return (d == 3) ? 3 : 4;
    endfunction

    function automatic logic [31:0] rst_of(int d);
        return (d == 3) ? 32'hDEADBEEF : 32'h0;
    endfunction

    function automatic obs_t reset_word(int d);
        return {rst_of(d), 1'b0, 1'b0, 2'b00};
    endfunction

    function automatic obs_t cur_word(int d);
        obs_t w;
        int   s;
        s      = int'(sel);
        w.data = (s < num_of(d)) ? in_bus[s*32 +: 32] : rst_of(d);
        w.vld  = in_valid;
        w.err  = (s >= num_of(d));
        w.tag  = sel;
        return w;
    endfunction

    function automatic obs_t model_out(int d);
        return ring[d][(cnt[d] - pipe_of(d)) & 15];
    endfunction

    task automatic model_push(int d, obs_t w);
        ring[d][cnt[d] & 15] = w;
        cnt[d] = cnt[d] + 1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            cnt[d] = 0;
            for (int p = 0; p < pipe_of(d); p++) model_push(d, reset_word(d));
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        for (int d = 0; d < ND; d++) begin
            if (flush) begin
                for (int p = 0; p < pipe_of(d); p++) model_push(d, reset_word(d));
            end else if (!stall) begin
                model_push(d, cur_word(d));
            end
        end
        #1;
    endtask

    function automatic logic [31:0] tbl(int k);
        return 32'h11111111 * (k + 1);
    endfunction

    task automatic set_table();
        for (int k = 0; k < 4; k++) in_bus[k*32 +: 32] = tbl(k);
    endtask

    task automatic test_reset();
        obs_t exp_w;
        Rst = 1'b1; set_table(); sel = 2'd0; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (act[d] !== reset_word(d)) begin
                errors++;
                $display("FAIL reset_initial dut%0d: got %h expected %h", d, act[d], reset_word(d));
            end
        end
        #2 Rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k + 1);
            tick();
        end
        #3 Rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (act[d] !== reset_word(d)) begin
                errors++;
                $display("FAIL reset_async dut%0d: got %h expected %h", d, act[d], reset_word(d));
            end
        end
        model_reset();
        #1 Rst = 1'b0;
        sel = 2'd2;
        tick();
        exp_w = {32'h33333333, 1'b1, 1'b0, 2'd2};
        checks++;
        if (act[0] !== exp_w) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", act[0], exp_w);
        end
    endtask

    task automatic test_latency();
        obs_t exp_w;
        set_table();
        for (int e = 1; e <= 6; e++) begin
            in_valid = (e <= 4);
            sel      = (e <= 4) ? 2'(e - 1) : 2'd0;
            tick();
            if (e >= 3) begin
                exp_w = {tbl(e - 3), 1'b1, 1'b0, 2'(e - 3)};
                checks++;
                if (act[2] !== exp_w) begin
                    errors++;
                    $display("FAIL latency edge%0d: got %h expected %h", e, act[2], exp_w);
                end
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act[d] !== model_out(d)) begin
                    errors++;
                    $display("FAIL latency_model dut%0d: got %h expected %h", d, act[d], model_out(d));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] seq [6];
        logic [31:0] exp_d;
        seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'h0; seq[3] = 32'h0; seq[4] = 32'hC; seq[5] = 32'h0;
        for (int e = 1; e <= 6; e++) begin
            stall    = (e == 3 || e == 4);
            in_valid = (e != 6);
            sel      = stall ? 2'($urandom_range(0, 3)) : 2'd0;
            in_bus   = {$urandom, $urandom, $urandom, $urandom};
            if (!stall) in_bus[31:0] = seq[e - 1];
            tick();
            if (e >= 3) begin
                exp_d = (e <= 4) ? 32'hA : (e == 5) ? 32'hB : 32'hC;
                checks++;
                if (act[1] !== {exp_d, 1'b1, 1'b0, 2'd0}) begin
                    errors++;
                    $display("FAIL stall edge%0d: got %h expected data %h valid 1", e, act[1], exp_d);
                end
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act[d] !== model_out(d)) begin
                    errors++;
                    $display("FAIL stall_model dut%0d: got %h expected %h", d, act[d], model_out(d));
                end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_flush();
        set_table();
        in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sel = 2'(k);
            tick();
        end
        stall = 1'b1; flush = 1'b1; sel = 2'd0;
        tick();
        checks++;
        if (act[2] !== {32'h0, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL flush_over_stall: got %h expected %h", act[2], {32'h0, 4'h0});
        end
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++;
            if (act[2].vld !== 1'b0) begin
                errors++;
                $display("FAIL flush_drain edge%0d: got valid %b expected 0", e, act[2].vld);
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act[d] !== model_out(d)) begin
                    errors++;
                    $display("FAIL flush_model dut%0d: got %h expected %h", d, act[d], model_out(d));
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        obs_t exp_w;
        set_table();
        in_valid = 1'b1; sel = 2'd3;
        tick();
        sel = 2'd1;
        tick();
        exp_w = {32'hDEADBEEF, 1'b1, 1'b1, 2'd3};
        checks++;
        if (act[3] !== exp_w) begin
            errors++;
            $display("FAIL oor_select: got %h expected %h", act[3], exp_w);
        end
        in_valid = 1'b0;
        tick();
        exp_w = {32'h22222222, 1'b1, 1'b0, 2'd1};
        checks++;
        if (act[3] !== exp_w) begin
            errors++;
            $display("FAIL oor_next_word: got %h expected %h", act[3], exp_w);
        end
    endtask

    task automatic test_bubble();
        obs_t exp_w [3];
        set_table();
        exp_w[0] = {tbl(0), 1'b1, 1'b0, 2'd0};
        exp_w[1] = {tbl(1), 1'b0, 1'b0, 2'd1};
        exp_w[2] = {tbl(2), 1'b1, 1'b0, 2'd2};
        for (int e = 1; e <= 5; e++) begin
            sel      = (e <= 3) ? 2'(e - 1) : 2'd0;
            in_valid = (e == 1 || e == 3);
            tick();
            if (e >= 2 && e <= 4) begin
                checks++;
                if (act[1] !== exp_w[e - 2]) begin
                    errors++;
                    $display("FAIL bubble edge%0d: got %h expected %h", e, act[1], exp_w[e - 2]);
                end
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act[d] !== model_out(d)) begin
                    errors++;
                    $display("FAIL bubble_model dut%0d: got %h expected %h", d, act[d], model_out(d));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in_bus   = {$urandom, $urandom, $urandom, $urandom};
            sel      = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            tick();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act[d] !== model_out(d)) begin
                    errors++;
                    $display("FAIL random%0d dut%0d: got %h expected %h", n, d, act[d], model_out(d));
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                #2 Rst = 1'b1;
                model_reset();
                #1;
                for (int d = 0; d < ND; d++) begin
                    checks++;
                    if (act[d] !== model_out(d)) begin
                        errors++;
                        $display("FAIL random_reset dut%0d: got %h expected %h", d, act[d], model_out(d));
                    end
                end
                #1 Rst = 1'b0;
            end
        end
        stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_out_of_range();
        test_bubble();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_mux_nto1.md
Name: pipelined_mux_nto1

Overview:
- Parametrised, registered N-input, W-bit select mux for datapath source selection: ALU operand forwarding, PC source, write-back source.
- The selected word passes through a configurable pipeline of PIPE register stages, which carry valid, select-error and select tags.
- Supports stall (hold all stages) and flush (squash all stages) from the hazard unit.
- Sits between stage registers in the MIPS datapath.

Parameters:
- WIDTH, 32: data width in bits per input.
- NUM_IN, 4: number of data inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN): select width; derived, not overridden.
- PIPE, 1: number of register stages, legal range 1..4; equals latency in cycles.
- RESET_VAL, 0: WIDTH-bit value loaded on reset and flush, and used for an out-of-range select.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input select.
- in_valid  input  1  marks the current sel/in_bus as a real operation.
- stall  input  1  holds all stages when high.
- flush  input  1  squashes all stages when high.
- out  output  WIDTH  data from the last stage.
- out_valid  output  1  valid bit from the last stage.
- out_sel  output  SEL_W  select value that produced out, for trace/debug.
- sel_err  output  1  high with out when that word's sel was >= NUM_IN.

Behaviour:
- Reset (Rst=1, asynchronous, no clock needed):
  - every stage loads data=RESET_VAL, valid=0, sel tag=0, err=0.
  - outputs therefore read out=RESET_VAL, out_valid=0, out_sel=0, sel_err=0 until reset is released.
- Release of Rst is used synchronously; the first capture happens on the first rising edge after deassertion.
- Stage 0 input is purely combinational:
  - data = in_bus slice [sel*WIDTH +: WIDTH] when sel < NUM_IN, else RESET_VAL.
  - err = (sel >= NUM_IN). Reachable only when NUM_IN is not a power of two.
  - valid = in_valid; the sel tag is sel itself.
- Per rising edge, priority is flush > stall > advance:
  - flush=1: all stages load data=RESET_VAL, valid=0, err=0, sel tag=0, regardless of stall. The word presented that cycle is also discarded.
  - stall=1, flush=0: all stages hold their contents. The stage 0 input is ignored and not buffered; the upstream stage must hold it.
  - Otherwise: stage 0 captures its input and stage i captures stage i-1 for i = 1..PIPE-1.
- Latency is exactly PIPE advancing edges from input to out. Stalled cycles do not count.
- Bubbles: with in_valid=0 the data is still captured (don't-care content) with valid=0. Downstream logic must qualify out with out_valid.
- err and the sel tag travel with their data word. sel_err is not sticky.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-pipeline discards all in-flight words immediately (asynchronous).
- No arithmetic is performed; data passes bit-exact.
- Width rules: sel is compared as unsigned against NUM_IN, and out-of-range never indexes past in_bus.
- The design must elaborate for every PIPE value in 1..4. An elaboration-time check fails for PIPE=0 or NUM_IN<2.

Decomposition:
- Shared package mips_pkg holds:
  - the WORD_W=32 constant;
  - named select encodings for datapath users (FWD_NONE=0, FWD_EXMEM=1, FWD_MEMWB=2);
  - a PIPE_MAX=4 constant.
- One sub-module, mux_pipe_stage: a single stage register of {data, valid, err, sel tag} with async reset, stall and flush. The top generates PIPE instances of it plus the combinational select.

Test Plan:
1. Reset: WIDTH=32, NUM_IN=4, PIPE=1, inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, in_valid=1. Assert Rst mid-cycle. Required: out=0 and out_valid=0 immediately, before any clock edge. After release, sel=2 gives out=0x33333333 with out_valid=1 one edge later.
2. Latency: PIPE=3, sel sequence 0,1,2,3 on consecutive edges, in_valid=1. Required: out shows 0x11111111, 0x22222222, 0x33333333, 0x44444444 on edges 3-6, with out_sel = 0,1,2,3.
3. Stall: PIPE=2 streaming 0xA, 0xB, 0xC. Assert stall for 2 cycles after 0xB enters. Required: out and out_valid are frozen during the stall, and 0xB emerges exactly 2 cycles later than without the stall.
4. Flush over stall: PIPE=3 with 3 valid words in flight. Assert stall=1 and flush=1 on the same edge. Required: the next cycle shows out=RESET_VAL and out_valid=0, and no flushed word ever appears on out.
5. Out-of-range select: NUM_IN=3, RESET_VAL=0xDEADBEEF, sel=3, in_valid=1, PIPE=2. Required: two edges later out=0xDEADBEEF, sel_err=1, out_valid=1, out_sel=3. The following word with sel=1 has sel_err=0.
6. Bubble: in_valid=0 with sel=1. Required: out_valid=0 PIPE edges later, while neighbouring valid words keep their order and values.
